// File: rtl/e_mdu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : e_mdu_pkg
// Description : Shared decode constants, operation enum and helpers for the
//               E-stage multiply/divide unit (HI/LO owner).
// Revision    : 1.0 - initial release
// ============================================================================
package e_mdu_pkg;

    // Primary opcode of R-type instructions
    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    // Function codes of the MDU-class instructions (shared with hazard unit
    // and the M-stage register for MFHI/MFLO forwarding)
    localparam logic [5:0] MFHI_S  = 6'h10;
    localparam logic [5:0] MTHI_S  = 6'h11;
    localparam logic [5:0] MFLO_S  = 6'h12;
    localparam logic [5:0] MTLO_S  = 6'h13;
    localparam logic [5:0] MULT_S  = 6'h18;
    localparam logic [5:0] MULTU_S = 6'h19;
    localparam logic [5:0] DIV_S   = 6'h1a;
    localparam logic [5:0] DIVU_S  = 6'h1b;

    // Operations the MDU acts upon; everything else decodes to MDU_NONE
    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    // A full HI/LO result pair
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_res_t;

    // Map opcode/funct onto an MDU operation
    function automatic mdu_op_e mdu_decode(input logic [5:0] opcode,
                                           input logic [5:0] funct);
        mdu_op_e op;
        op = MDU_NONE;
        if (opcode == OP_SPECIAL) begin
            case (funct)
                MULT_S:  op = MDU_MULT;
                MULTU_S: op = MDU_MULTU;
                DIV_S:   op = MDU_DIV;
                DIVU_S:  op = MDU_DIVU;
                MTHI_S:  op = MDU_MTHI;
                MTLO_S:  op = MDU_MTLO;
                default: op = MDU_NONE;
            endcase
        end
        return op;
    endfunction

    // True for the operations that occupy the unit for several cycles
    function automatic logic mdu_is_arith(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // Two's-complement negate when neg is set
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : e_mdu
// Description : E-stage multiply/divide unit. Decodes MULT/MULTU/DIV/DIVU and
//               MTHI/MTLO, computes the result at start, models latency with a
//               down-counter and commits to the architectural HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    output logic        out_start,
    output logic        out_busy,
    output logic [31:0] out_hi,
    output logic [31:0] out_lo
);

    localparam logic [3:0] c_mult_cnt = MULT_CYCLES[3:0];
    localparam logic [3:0] c_div_cnt  = DIV_CYCLES[3:0];

    // Sequential state
    logic        r_busy;
    logic [3:0]  r_cnt;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic        r_res_valid;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Decode and arithmetic
    mdu_op_e     w_op;
    logic        w_start;
    logic        w_is_div;
    logic        w_rt_zero;
    logic [31:0] w_divisor;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_quot_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;
    mdu_res_t    w_result;

    // Register-number and shamt fields are not needed for decode
    logic        w_unused_instr;
    assign w_unused_instr = ^in_instr[25:6];

    assign w_op      = mdu_decode(in_instr[31:26], in_instr[5:0]);
    assign w_start   = mdu_is_arith(w_op) && !r_busy;
    assign w_is_div  = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
    assign w_rt_zero = (in_rt == 32'd0);

    // A zero divisor is replaced by 1 so the divider never sees 0; the result
    // is discarded anyway through r_res_valid.
    assign w_divisor = w_rt_zero ? 32'd1 : in_rt;

    // The low 64 bits of a product of sign-extended operands equal the signed
    // 64-bit product, so one unsigned multiply covers MULT.
    assign w_prod_s = {{32{in_rs[31]}}, in_rs} * {{32{in_rt[31]}}, in_rt};
    assign w_prod_u = {32'd0, in_rs} * {32'd0, in_rt};

    // Signed division through magnitudes: quotient truncates toward zero and
    // the remainder takes the dividend's sign. This also keeps the
    // most-negative / -1 case well defined (quotient wraps to 0x80000000).
    assign w_rs_mag   = neg_if(in_rs[31], in_rs);
    assign w_rt_mag   = neg_if(w_divisor[31], w_divisor);
    assign w_quot_mag = w_rs_mag / w_rt_mag;
    assign w_rem_mag  = w_rs_mag % w_rt_mag;
    assign w_quot_u   = in_rs / w_divisor;
    assign w_rem_u    = in_rs % w_divisor;

    // Select the HI/LO pair for the decoded operation
    always_comb begin
        w_result = '0;
        case (w_op)
            MDU_MULT: begin
                w_result.hi = w_prod_s[63:32];
                w_result.lo = w_prod_s[31:0];
            end
            MDU_MULTU: begin
                w_result.hi = w_prod_u[63:32];
                w_result.lo = w_prod_u[31:0];
            end
            MDU_DIV: begin
                w_result.hi = neg_if(in_rs[31], w_rem_mag);
                w_result.lo = neg_if(in_rs[31] ^ w_divisor[31], w_quot_mag);
            end
            MDU_DIVU: begin
                w_result.hi = w_rem_u;
                w_result.lo = w_quot_u;
            end
            default: w_result = '0;
        endcase
    end

    // Busy/counter sequencing, result staging and HI/LO commit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_cnt       <= 4'd0;
            r_res_hi    <= 32'd0;
            r_res_lo    <= 32'd0;
            r_res_valid <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
        end else if (r_busy) begin
            // Any MDU instruction arriving now is ignored
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_busy <= 1'b0;
                if (r_res_valid) begin
                    r_hi <= r_res_hi;
                    r_lo <= r_res_lo;
                end
            end
        end else if (w_start) begin
            r_busy      <= 1'b1;
            r_cnt       <= w_is_div ? c_div_cnt : c_mult_cnt;
            r_res_hi    <= w_result.hi;
            r_res_lo    <= w_result.lo;
            r_res_valid <= !(w_is_div && w_rt_zero);
        end else if (w_op == MDU_MTHI) begin
            r_hi <= in_rs;
        end else if (w_op == MDU_MTLO) begin
            r_lo <= in_rs;
        end
    end

    assign out_start = w_start;
    assign out_busy  = r_busy;
    assign out_hi    = r_hi;
    assign out_lo    = r_lo;

endmodule
`default_nettype wire

// File: doc/e_mdu.md
# e_mdu

Multi-cycle multiply/divide unit for the P6 five-stage MIPS pipeline. It sits in the E stage beside the ALU and decodes the E-stage instruction itself. It executes MULT/MULTU/DIV/DIVU with fixed latency and handles MTHI/MTLO. It owns the architectural HI/LO registers and produces the `in_hi`/`in_lo` values that the M-stage pipeline register captures for MFHI/MFLO forwarding. Its `out_start`/`out_busy` outputs feed the hazard unit's stall logic.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (legal range 1..15).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `in_instr`  in  32  E-stage instruction word; 0 (nop) when E holds a bubble.
- `in_rs`  in  32  forwarded rs operand.
- `in_rt`  in  32  forwarded rt operand.
- `out_start`  out  1  combinational; 1 when `in_instr` is MULT/MULTU/DIV/DIVU and `out_busy`=0.
- `out_busy`  out  1  registered; 1 while an operation is in flight.
- `out_hi`  out  32  architectural HI (registered).
- `out_lo`  out  32  architectural LO (registered).

## Operation
- Decode uses opcode `Special` plus function codes MULT_S, MULTU_S, DIV_S, DIVU_S, MTHI_S, MTLO_S.
- State: `busy` flag, 4-bit down-counter `cnt`, 32-bit `res_hi`/`res_lo` staging registers, `res_valid` flag (0 for divide-by-zero), and `out_hi`/`out_lo`.
- Start (`out_start`=1) at an edge:
  - `res_hi`/`res_lo` <= result; `busy` <= 1.
  - `cnt` <= MULT_CYCLES or DIV_CYCLES.
  - `res_valid` <= !(divide && `in_rt`==0).
- Results:
  - MULT: signed 64-bit product; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 64-bit product, same split.
  - DIV: lo = signed quotient, truncated toward zero; hi = remainder, carrying the dividend's sign.
  - DIVU: unsigned quotient and remainder.
- While busy, each edge: `cnt` <= `cnt`-1. At the edge where `cnt`==1: `busy` <= 0; if `res_valid`, `out_hi`/`out_lo` <= `res_hi`/`res_lo`.
- Divide by zero: runs the full DIV_CYCLES; HI/LO stay unchanged.
- MTHI/MTLO when not busy: `out_hi` (or `out_lo`) <= `in_rs` at the next edge.
- MTHI/MTLO/MULT/DIV arriving while busy: ignored (no state change). The hazard unit guarantees this never happens architecturally; the rule exists only so the behaviour is defined.
- Reset, including mid-operation: `busy`=0, `cnt`=0, `res_*`=0, `res_valid`=0, `out_hi`=`out_lo`=0. The pending result is discarded and never written.

## Timing
- Start in cycle t: `out_start`=1 during t; `out_busy`=1 for cycles t+1 .. t+N (N = MULT_CYCLES or DIV_CYCLES).
- `out_hi`/`out_lo` carry the new result from cycle t+N+1, when `out_busy`=0.
- MFHI/MFLO reaching E at t+N+1 reads the new value.
- Hazard contract: stall D while (`out_start` | `out_busy`) and the D instruction is an MDU-class instruction (mult/div/mfhi/mflo/mthi/mtlo). No other stall is required.
- Back-to-back: a new start is accepted in cycle t+N+1, since `out_busy` is already 0.
- MTHI/MTLO in cycle t updates the output in cycle t+1.
- Reset values of all outputs: `out_busy`=0, `out_hi`=0, `out_lo`=0. `out_start` follows `in_instr`.

## Structure
- Function-code macros (MULT_S, MULTU_S, DIV_S, DIVU_S, MTHI_S, MTLO_S, MFHI_S, MFLO_S) belong in the shared `_const.v` header next to `Special`. The hazard unit and the M register use the same macros.
- No sub-module. Decode, counter and result staging stay in one file.
- The arithmetic uses behavioural `*` `/` `%`, computed at start. The latency is modelled by the counter only.

## Test plan
- Reset check: hold `reset` 2 cycles -> `out_hi`=`out_lo`=0, `out_busy`=0.
- MULT with rs=0xFFFFFFFD (-3), rt=7:
  - `out_start`=1 for 1 cycle, then `out_busy`=1 for exactly 5 cycles.
  - Afterwards `out_hi`=0xFFFFFFFF, `out_lo`=0xFFFFFFEB.
- DIVU 0xFFFFFFFF / 0x10 -> busy 10 cycles, then `out_lo`=0x0FFFFFFF, `out_hi`=0x0000000F.
- DIV -7/2 -> `out_lo`=0xFFFFFFFD, `out_hi`=0xFFFFFFFF.
- Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIV rt=0 -> busy 10 cycles; HI/LO remain 0x1234/0x5678.
- Reset mid-operation: assert `reset` at busy cycle 3 of MULT 2×3, with MULTU 5×5 presented while busy -> the MULTU is ignored. After reset `out_busy`=0 and HI=LO=0. No write follows in later cycles with `in_instr`=0.
